// File: rtl/rvh_noc_pkg.sv
// Shared NoC types: flit width, VC id width and the port encoding
// used for look-ahead routing.
package rvh_noc_pkg;

  // Flit payload width used for the default flit type
  localparam int FLIT_LENGTH = 256;

  // Widest VC id a downstream credit return may carry
  localparam int VC_ID_NUM_MAX   = 16;
  localparam int VC_ID_NUM_MAX_W = $clog2(VC_ID_NUM_MAX);

  // Router port encoding: N0, S1, E2, W3, local ports 4-7
  typedef enum logic [2:0] {
    PORT_N  = 3'd0,
    PORT_S  = 3'd1,
    PORT_E  = 3'd2,
    PORT_W  = 3'd3,
    PORT_L0 = 3'd4,
    PORT_L1 = 3'd5,
    PORT_L2 = 3'd6,
    PORT_L3 = 3'd7
  } io_port_t;

endpackage

// File: rtl/output_port_credit_cnt.sv
// Credit counter for one downstream VC. It resets to full (VC_DEPTH), counts
// down on a consume and up on a returned credit. Illegal moves (underflow or
// overflow) leave the count alone and raise a one-cycle error pulse.
module output_port_credit_cnt #(
  parameter int VC_DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic consume_i,
  input  logic return_i,
  output logic avail_o,
  output logic err_o
);

  localparam int CNT_W = $clog2(VC_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VC_DEPTH);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count; a consume and a return in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    unique case ({consume_i, return_i})
      2'b10: begin
        if (cnt_q == '0) err_o = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == CNT_FULL) err_o = 1'b1;
        else                   cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Counter register; reset means the downstream buffer is empty
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= CNT_FULL;
    else       cnt_q <= cnt_d;
  end

  assign avail_o = (cnt_q != '0);

endmodule

// File: rtl/output_port_tx.sv
// Router output port transmit stage: per-VC credit tracking towards the
// downstream router plus the flit path from switch traversal to the link.
// Build option: define OUTPORT_TX_REG_EN to register the tx_* outputs (one
// cycle latency); otherwise they are a combinational pass-through of st_*.
module output_port_tx
  import rvh_noc_pkg::*;
#(
  parameter type flit_payload_t = logic [FLIT_LENGTH-1:0],
  parameter int  VC_NUM         = 1,
  parameter int  VC_DEPTH       = 1,
  parameter int  VC_NUM_IDX_W   = (VC_NUM > 1 ? $clog2(VC_NUM) : 1),
  parameter int  OUTPUT_PORT_NO = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       consume_v_i,
  input  logic [VC_NUM_IDX_W-1:0]    consume_vc_id_i,
  input  logic                       st_flit_v_i,
  input  flit_payload_t              st_flit_i,
  input  logic [VC_NUM_IDX_W-1:0]    st_flit_vc_id_i,
  input  io_port_t                   st_flit_look_ahead_routing_i,
  output logic                       tx_flit_pend_o,
  output logic                       tx_flit_v_o,
  output flit_payload_t              tx_flit_o,
  output logic [VC_NUM_IDX_W-1:0]    tx_flit_vc_id_o,
  output io_port_t                   tx_flit_look_ahead_routing_o,
  input  logic                       tx_lcrd_v_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] tx_lcrd_id_i,
  output logic [VC_NUM-1:0]          vc_credit_avail_o,
  output logic                       credit_err_o
);

  // Port numbers outside the N/S/E/W/L0-L3 range are a configuration bug
  if (OUTPUT_PORT_NO < 0 || OUTPUT_PORT_NO > 7) begin : g_bad_port_no
    $error("output_port_tx: OUTPUT_PORT_NO out of range");
  end

  logic [VC_NUM-1:0] consume_sel;
  logic [VC_NUM-1:0] return_sel;
  logic [VC_NUM-1:0] cnt_err;
  logic              id_err;
  logic              err_d;
  logic              err_q;

  // Decode consume and credit-return requests to per-VC strobes; an id with
  // no matching VC selects nothing and is flagged instead
  always_comb begin
    consume_sel = '0;
    return_sel  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      consume_sel[v] = consume_v_i && (int'(consume_vc_id_i) == v);
      return_sel[v]  = tx_lcrd_v_i && (int'(tx_lcrd_id_i) == v);
    end
    id_err = (consume_v_i && (int'(consume_vc_id_i) >= VC_NUM)) ||
             (tx_lcrd_v_i && (int'(tx_lcrd_id_i) >= VC_NUM));
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    output_port_credit_cnt #(
      .VC_DEPTH (VC_DEPTH)
    ) u_credit_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .consume_i (consume_sel[v]),
      .return_i  (return_sel[v]),
      .avail_o   (vc_credit_avail_o[v]),
      .err_o     (cnt_err[v])
    );
  end

  // Any protocol violation latches the error flag until the next reset
  always_comb begin
    err_d = err_q | id_err | (|cnt_err);
  end

  // Sticky error register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign credit_err_o = err_q;

`ifdef OUTPORT_TX_REG_EN
  logic                    tx_v_d;
  logic                    tx_v_q;
  flit_payload_t           tx_flit_d;
  flit_payload_t           tx_flit_q;
  logic [VC_NUM_IDX_W-1:0] tx_vc_id_d;
  logic [VC_NUM_IDX_W-1:0] tx_vc_id_q;
  io_port_t                tx_route_d;
  io_port_t                tx_route_q;

  // Next link-register contents are simply the switch-traversal inputs
  always_comb begin
    tx_v_d     = st_flit_v_i;
    tx_flit_d  = st_flit_i;
    tx_vc_id_d = st_flit_vc_id_i;
    tx_route_d = st_flit_look_ahead_routing_i;
  end

  // Link output register; reset drops any flit in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_v_q     <= 1'b0;
      tx_flit_q  <= '0;
      tx_vc_id_q <= '0;
      tx_route_q <= PORT_N;
    end else begin
      tx_v_q     <= tx_v_d;
      tx_flit_q  <= tx_flit_d;
      tx_vc_id_q <= tx_vc_id_d;
      tx_route_q <= tx_route_d;
    end
  end

  assign tx_flit_pend_o               = st_flit_v_i;
  assign tx_flit_v_o                  = tx_v_q;
  assign tx_flit_o                    = tx_flit_q;
  assign tx_flit_vc_id_o              = tx_vc_id_q;
  assign tx_flit_look_ahead_routing_o = tx_route_q;
`else
  // The grant cycle precedes the traversal cycle, so a grant announces a flit
  assign tx_flit_pend_o               = consume_v_i;
  assign tx_flit_v_o                  = st_flit_v_i;
  assign tx_flit_o                    = st_flit_i;
  assign tx_flit_vc_id_o              = st_flit_vc_id_i;
  assign tx_flit_look_ahead_routing_o = st_flit_look_ahead_routing_i;
`endif

endmodule

// File: tb/tb_output_port_tx.sv
// Scoreboard bench for output_port_tx with VC_NUM=4, VC_DEPTH=2.
// Credit state is tracked by a simple per-VC credit array; flits are queued
// when driven and matched in order when the DUT presents them.
module tb_output_port_tx;
  import rvh_noc_pkg::*;

  localparam int VC_NUM   = 4;
  localparam int VC_DEPTH = 2;
  localparam int IDX_W    = 2;

  typedef logic [255:0] payload_t;

  typedef struct {
    logic [IDX_W-1:0] vc;
    payload_t         data;
    io_port_t         route;
  } flit_exp_t;

  typedef struct {
    logic [VC_NUM-1:0] avail;
    logic              err;
  } cred_exp_t;

  logic                       clk;
  logic                       rstn;
  logic                       consume_v_i;
  logic [IDX_W-1:0]           consume_vc_id_i;
  logic                       st_flit_v_i;
  payload_t                   st_flit_i;
  logic [IDX_W-1:0]           st_flit_vc_id_i;
  io_port_t                   st_flit_look_ahead_routing_i;
  logic                       tx_flit_pend_o;
  logic                       tx_flit_v_o;
  payload_t                   tx_flit_o;
  logic [IDX_W-1:0]           tx_flit_vc_id_o;
  io_port_t                   tx_flit_look_ahead_routing_o;
  logic                       tx_lcrd_v_i;
  logic [VC_ID_NUM_MAX_W-1:0] tx_lcrd_id_i;
  logic [VC_NUM-1:0]          vc_credit_avail_o;
  logic                       credit_err_o;

  int        total = 0;
  int        bad   = 0;
  bit        started = 0;
  bit        prev_pend = 0;
  int        credits[VC_NUM];
  bit        model_err;
  bit        flit_due;
  flit_exp_t due_flit;
  flit_exp_t flit_q[$];
  cred_exp_t cred_q[$];

  output_port_tx #(
    .flit_payload_t (payload_t),
    .VC_NUM         (VC_NUM),
    .VC_DEPTH       (VC_DEPTH),
    .VC_NUM_IDX_W   (IDX_W),
    .OUTPUT_PORT_NO (2)
  ) dut (
    .clk                          (clk),
    .rstn                         (rstn),
    .consume_v_i                  (consume_v_i),
    .consume_vc_id_i              (consume_vc_id_i),
    .st_flit_v_i                  (st_flit_v_i),
    .st_flit_i                    (st_flit_i),
    .st_flit_vc_id_i              (st_flit_vc_id_i),
    .st_flit_look_ahead_routing_i (st_flit_look_ahead_routing_i),
    .tx_flit_pend_o               (tx_flit_pend_o),
    .tx_flit_v_o                  (tx_flit_v_o),
    .tx_flit_o                    (tx_flit_o),
    .tx_flit_vc_id_o              (tx_flit_vc_id_o),
    .tx_flit_look_ahead_routing_o (tx_flit_look_ahead_routing_o),
    .tx_lcrd_v_i                  (tx_lcrd_v_i),
    .tx_lcrd_id_i                 (tx_lcrd_id_i),
    .vc_credit_avail_o            (vc_credit_avail_o),
    .credit_err_o                 (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic payload_t rndPayload();
    payload_t p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // Credit bookkeeping: net change per VC, illegal results are refused
  function automatic void modelUpdate(input bit cv, input int cvc, input bit rv, input int rvc);
    int delta[VC_NUM];
    int n;
    for (int v = 0; v < VC_NUM; v++) delta[v] = 0;
    if (cv) begin
      if (cvc >= VC_NUM) model_err = 1'b1;
      else               delta[cvc] -= 1;
    end
    if (rv) begin
      if (rvc >= VC_NUM) model_err = 1'b1;
      else               delta[rvc] += 1;
    end
    for (int v = 0; v < VC_NUM; v++) begin
      n = credits[v] + delta[v];
      if (n < 0 || n > VC_DEPTH) model_err = 1'b1;
      else                       credits[v] = n;
    end
  endfunction

  // One clock of stimulus; a consume this cycle yields a flit next cycle
  task automatic applyStimulus(input bit cv, input int cvc, input bit rv, input int rvc, input payload_t pl);
    flit_exp_t nf;
    cred_exp_t ce;
    consume_v_i     = cv;
    consume_vc_id_i = cvc[IDX_W-1:0];
    tx_lcrd_v_i     = rv;
    tx_lcrd_id_i    = rvc[VC_ID_NUM_MAX_W-1:0];
    st_flit_v_i     = flit_due;
    st_flit_i       = due_flit.data;
    st_flit_vc_id_i = due_flit.vc;
    st_flit_look_ahead_routing_i = due_flit.route;
    if (flit_due) flit_q.push_back(due_flit);
    nf.vc    = cvc[IDX_W-1:0];
    nf.data  = pl;
    nf.route = io_port_t'($urandom_range(0, 7));
    due_flit = nf;
    flit_due = cv;
    @(posedge clk);
    #1;
    modelUpdate(cv, cvc, rv, rvc);
    for (int v = 0; v < VC_NUM; v++) ce.avail[v] = (credits[v] != 0);
    ce.err = model_err;
    cred_q.push_back(ce);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 0, rndPayload());
  endtask

  task automatic doReset();
    consume_v_i = 1'b0;
    consume_vc_id_i = '0;
    tx_lcrd_v_i = 1'b0;
    tx_lcrd_id_i = '0;
    st_flit_v_i = 1'b0;
    st_flit_i = '0;
    st_flit_vc_id_i = '0;
    st_flit_look_ahead_routing_i = PORT_N;
    flit_due = 1'b0;
    flit_q.delete();
    cred_q.delete();
    for (int v = 0; v < VC_NUM; v++) credits[v] = VC_DEPTH;
    model_err = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("reset_avail", vc_credit_avail_o, 4'b1111);
    checkOutput("reset_err", credit_err_o, 1'b0);
    checkOutput("reset_tx_v", tx_flit_v_o, 1'b0);
    checkOutput("reset_pend", tx_flit_pend_o, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic checkNow(input string name, input logic [VC_NUM-1:0] avail, input logic err);
    #2;
    checkOutput({name, "_avail"}, vc_credit_avail_o, avail);
    checkOutput({name, "_err"}, credit_err_o, err);
  endtask

  // Monitor: credit state every cycle, flits in order whenever valid
  always @(negedge clk) begin
    cred_exp_t ce;
    flit_exp_t fe;
    if (!rstn) begin
      prev_pend = 1'b0;
    end else if (started) begin
      if (cred_q.size() > 0) begin
        ce = cred_q.pop_front();
        checkOutput("credit_avail", vc_credit_avail_o, ce.avail);
        checkOutput("credit_err", credit_err_o, ce.err);
      end
      checkOutput("pend_before_valid", tx_flit_v_o, prev_pend);
      if (tx_flit_v_o) begin
        if (flit_q.size() == 0) begin
          checkOutput("unexpected_flit", 1'b1, 1'b0);
        end else begin
          fe = flit_q.pop_front();
          checkOutput("flit_vc", tx_flit_vc_id_o, fe.vc);
          checkOutput("flit_data", tx_flit_o, fe.data);
          checkOutput("flit_route", tx_flit_look_ahead_routing_o, fe.route);
        end
      end
      prev_pend = tx_flit_pend_o;
    end
  end

  initial begin
    int cvc;
    int rvc;
    bit cv;
    bit rv;
    rstn = 1'b1;
    flit_due = 1'b0;
    consume_v_i = 1'b0;
    consume_vc_id_i = '0;
    tx_lcrd_v_i = 1'b0;
    tx_lcrd_id_i = '0;
    st_flit_v_i = 1'b0;
    st_flit_i = '0;
    st_flit_vc_id_i = '0;
    st_flit_look_ahead_routing_i = PORT_N;
    #2;
    doReset();
    started = 1'b1;

    // Drain VC2, then return one credit
    applyStimulus(1'b1, 2, 1'b0, 0, rndPayload());
    applyStimulus(1'b1, 2, 1'b0, 0, rndPayload());
    checkNow("vc2_drained", 4'b1011, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 2, rndPayload());
    checkNow("vc2_returned", 4'b1111, 1'b0);

    // Same-VC cancel and different-VC concurrent updates
    applyStimulus(1'b1, 1, 1'b0, 0, rndPayload());
    applyStimulus(1'b1, 1, 1'b1, 1, rndPayload());
    applyStimulus(1'b1, 1, 1'b0, 0, rndPayload());
    checkNow("vc1_cancel", 4'b1101, 1'b0);
    applyStimulus(1'b1, 3, 1'b1, 1, rndPayload());
    applyStimulus(1'b1, 0, 1'b1, 3, rndPayload());
    applyStimulus(1'b0, 0, 1'b1, 1, rndPayload());
    applyStimulus(1'b0, 0, 1'b1, 0, rndPayload());
    applyStimulus(1'b0, 0, 1'b1, 2, rndPayload());
    checkNow("all_full", 4'b1111, 1'b0);

    // Directed flit on VC3 with payload 0xA5
    applyStimulus(1'b1, 3, 1'b0, 0, 256'hA5);
    idle();
    applyStimulus(1'b0, 0, 1'b1, 3, rndPayload());
    idle();

    // Random legal traffic: never consume empty, never overfill
    for (int i = 0; i < 150; i++) begin
      cvc = $urandom_range(0, VC_NUM - 1);
      rvc = $urandom_range(0, VC_NUM - 1);
      cv  = ($urandom_range(0, 1) == 1) && (credits[cvc] > 0);
      rv  = ($urandom_range(0, 1) == 1) && (credits[rvc] < VC_DEPTH);
      applyStimulus(cv, cvc, rv, rvc, rndPayload());
    end
    idle();
    doReset();

    // Underflow, overflow and out-of-range credit id
    applyStimulus(1'b1, 0, 1'b0, 0, rndPayload());
    applyStimulus(1'b1, 0, 1'b0, 0, rndPayload());
    checkNow("vc0_empty", 4'b1110, 1'b0);
    applyStimulus(1'b1, 0, 1'b0, 0, rndPayload());
    checkNow("vc0_underflow", 4'b1110, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 0, rndPayload());
    applyStimulus(1'b0, 0, 1'b1, 0, rndPayload());
    applyStimulus(1'b0, 0, 1'b1, 0, rndPayload());
    applyStimulus(1'b0, 0, 1'b1, 5, rndPayload());
    checkNow("vc0_overflow", 4'b1111, 1'b1);
    applyStimulus(1'b1, 0, 1'b0, 0, rndPayload());
    applyStimulus(1'b1, 0, 1'b0, 0, rndPayload());
    checkNow("vc0_held_full", 4'b1110, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 0, rndPayload());
    applyStimulus(1'b0, 0, 1'b1, 0, rndPayload());

    // Random traffic including illegal requests
    for (int i = 0; i < 150; i++) begin
      cvc = $urandom_range(0, VC_NUM - 1);
      rvc = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, VC_NUM - 1);
      cv  = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 1) == 1);
      applyStimulus(cv, cvc, rv, rvc, rndPayload());
    end

    // Reset mid-operation with VC2 empty and a flit in flight
    doReset();
    applyStimulus(1'b1, 2, 1'b0, 0, rndPayload());
    applyStimulus(1'b1, 2, 1'b0, 0, rndPayload());
    checkNow("vc2_empty", 4'b1011, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 0, rndPayload());
    doReset();
    checkNow("after_midreset", 4'b1111, 1'b0);
    idle();
    idle();
    idle();

    checkOutput("flits_drained", flit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
